// File: rtl/pulse_pkg.sv
// Shared types for the pulse stretcher.
// Provides the three-state FSM encoding used by pulse_stretcher.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns a single-cycle tick into a level pulse of
// programmable length, followed by a mandatory low gap.
//
// Ports:
//   CLK      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   tick     single-cycle request
//   len      pulse length in cycles, sampled on an accepted tick
//   level    stretched pulse (registered)
//   busy     high whenever the FSM is not idle (registered)
//   dropped  one-cycle flag the cycle after a rejected tick (registered)
//
// state | meaning
// IDLE  | waiting for a tick with nonzero len
// HIGH  | level asserted, count = remaining HIGH cycles - 1
// GAP   | enforced low gap, count = remaining GAP cycles - 1
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          RETRIGGER = 1'b1,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] len,
  output logic             level,
  output logic             busy,
  output logic             dropped
);

  if ((GAP_LEN >> WIDTH) != 0) begin : g_gap_len_chk
    $error("pulse_stretcher: GAP_LEN does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] GAP_RLOAD = WIDTH'(GAP_LEN - 1);

  pulse_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             level_q, busy_q, dropped_q;
  logic             drop_d;
  logic             len_ok;

  assign len_ok = (len != ZERO);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // len==0 is silently ignored, not flagged as dropped
        if (tick && len_ok) begin
          state_d = HIGH;
          count_d = len - ONE;
        end
      end
      HIGH: begin
        if (tick && RETRIGGER && len_ok) begin
          count_d = len - ONE;
        end else begin
          if (tick && !RETRIGGER) drop_d = 1'b1;
          if (count_q == ZERO) begin
            if (GAP_LEN != 0) begin
              state_d = GAP;
              count_d = GAP_RLOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - ONE;
          end
        end
      end
      GAP: begin
        if (tick) drop_d = 1'b1;
        if (count_q == ZERO) state_d = IDLE;
        else                 count_d = count_q - ONE;
      end
      default: begin
        state_d = IDLE;
        count_d = ZERO;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= ZERO;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      level_q   <= (state_d == HIGH);
      busy_q    <= (state_d != IDLE);
      dropped_q <= drop_d;
    end
  end

  assign level   = level_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  logic       clk;
  logic       reset_n;
  logic       tick1, tick0;
  logic [7:0] len1, len0;
  logic       level1, busy1, dropped1;
  logic       level0, busy0, dropped0;

  int checks   = 0;
  int failures = 0;
  string cur_test = "reset";

  typedef struct {
    bit    sel;
    bit    l;
    bit    b;
    bit    d;
    int    cyc;
    string name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [2:0] mon_act;

  pulse_stretcher #(.WIDTH(8), .RETRIGGER(1'b1), .GAP_LEN(2)) u_r1 (
    .CLK(clk), .reset_n(reset_n), .tick(tick1), .len(len1),
    .level(level1), .busy(busy1), .dropped(dropped1)
  );

  pulse_stretcher #(.WIDTH(8), .RETRIGGER(1'b0), .GAP_LEN(2)) u_r0 (
    .CLK(clk), .reset_n(reset_n), .tick(tick0), .len(len0),
    .level(level0), .busy(busy0), .dropped(dropped0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle with a pending expectation is compared 1 time unit
  // after the rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = mon_e.sel ? {level1, busy1, dropped1} : {level0, busy0, dropped0};
      checks++;
      if (mon_act !== {mon_e.l, mon_e.b, mon_e.d}) begin
        failures++;
        $display("FAIL %s cycle=%0d level/busy/dropped got=%b want=%b",
                 mon_e.name, mon_e.cyc, mon_act, {mon_e.l, mon_e.b, mon_e.d});
      end
    end
  end

  function automatic bit in_r(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  task automatic chk(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, act, want);
    end
  endtask

  // Drive one request before the next rising edge and queue the outputs
  // expected in the cycle that follows that edge (cycle c).
  task automatic cyc(input bit s, input bit t, input int l,
                     input bit el, input bit eb, input bit ed, input int c);
    exp_t e;
    @(negedge clk);
    tick1 = 1'b0; len1 = 8'd0; tick0 = 1'b0; len0 = 8'd0;
    if (s) begin tick1 = t; len1 = 8'(l); end
    else   begin tick0 = t; len0 = 8'(l); end
    e.sel = s; e.l = el; e.b = eb; e.d = ed; e.cyc = c; e.name = cur_test;
    exp_q.push_back(e);
  endtask

  task automatic idle_gap();
    @(negedge clk);
    tick1 = 1'b0; len1 = 8'd0; tick0 = 1'b0; len0 = 8'd0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    tick1 = 1'b0; len1 = 8'd0; tick0 = 1'b0; len0 = 8'd0;
    #12;
    chk("reset_level",   level1,   1'b0);
    chk("reset_busy",    busy1,    1'b0);
    chk("reset_dropped", dropped1, 1'b0);
    chk("reset_busy_r0", busy0,    1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    cur_test = "basic";
    for (int c = 1; c <= 7; c++)
      cyc(1, c == 1, 3, in_r(c, 1, 3), in_r(c, 1, 5), 1'b0, c);
    idle_gap();

    cur_test = "retrig_len0";
    for (int c = 1; c <= 7; c++)
      cyc(1, c == 1 || c == 2, (c == 1) ? 3 : 0, in_r(c, 1, 3), in_r(c, 1, 5), 1'b0, c);
    idle_gap();

    cur_test = "retrigger";
    for (int c = 1; c <= 11; c++)
      cyc(1, c == 1 || c == 4, 4, in_r(c, 1, 7), in_r(c, 1, 9), 1'b0, c);
    idle_gap();

    cur_test = "retrig_last";
    for (int c = 1; c <= 8; c++)
      cyc(1, c == 1 || c == 3, 2, in_r(c, 1, 4), in_r(c, 1, 6), 1'b0, c);
    idle_gap();

    cur_test = "no_retrigger";
    for (int c = 1; c <= 9; c++)
      cyc(0, c == 1 || c == 3 || c == 6, 4, in_r(c, 1, 4), in_r(c, 1, 6),
          c == 3 || c == 6, c);
    idle_gap();

    cur_test = "len1";
    for (int c = 1; c <= 5; c++)
      cyc(0, c == 1, 1, c == 1, in_r(c, 1, 3), 1'b0, c);
    idle_gap();

    cur_test = "gap_boundary";
    for (int c = 1; c <= 11; c++)
      cyc(1, c == 1 || c == 5 || c == 6, 2, in_r(c, 1, 2) || in_r(c, 6, 7),
          in_r(c, 1, 4) || in_r(c, 6, 9), c == 5, c);
    idle_gap();

    cur_test = "len0";
    for (int c = 1; c <= 3; c++)
      cyc(1, c == 1, 0, 1'b0, 1'b0, 1'b0, c);
    idle_gap();

    cur_test = "len255";
    for (int c = 1; c <= 259; c++)
      cyc(1, c == 1, 255, in_r(c, 1, 255), in_r(c, 1, 257), 1'b0, c);
    idle_gap();

    cur_test = "async_reset";
    cyc(1, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1);
    cyc(1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2);
    @(posedge clk);
    #3;
    chk("pre_reset_level", level1, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_level", level1, 1'b0);
    chk("async_busy",  busy1,  1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cur_test = "after_reset";
    for (int c = 1; c <= 5; c++)
      cyc(1, c == 1, 2, in_r(c, 1, 2), in_r(c, 1, 4), 1'b0, c);

    @(negedge clk);
    tick1 = 1'b0; len1 = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
